// File: rtl/servo_bank_ctrl.sv
// Multi-channel servo PWM generator: commands land in a per-channel shadow register and are
// applied at the frame boundary, and a settle timer per channel drives busy/done flags.
module servo_bank_ctrl #(
  parameter int N_CH          = 4,
  parameter int POS_W         = 8,
  parameter int MAX_POS       = 180,
  parameter int RESET_POS     = 90,
  parameter int PERIOD_CYC    = 2_000_000,
  parameter int MIN_PULSE_CYC = 50_000,
  parameter int STEP_CYC      = 1_111,
  parameter int SETTLE_CYC    = 30_000_000,
  parameter int CNT_W         = 32,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [POS_W-1:0]  cmd_pos,
  output logic [N_CH-1:0]   pwm_out,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   done_pulse,
  output logic              err_range
);

  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic {
    IDLE,
    MOVING
  } settleState_e;

  logic                 alive_q;
  logic [CNT_W-1:0]     frameCnt_q;
  logic [CNT_W-1:0]     frameCnt_d;
  logic [POS_W-1:0]     shadow_q [N_CH];
  logic [POS_W-1:0]     active_q [N_CH];
  logic [N_CH-1:0]      pending_q;
  logic [N_CH-1:0]      pwm_q;
  logic [N_CH-1:0]      busy_q;
  logic [N_CH-1:0]      done_q;
  logic                 err_q;
  settleState_e         state_q [N_CH];
  logic [CNT_W-1:0]     tmr_q [N_CH];

  logic                 boundary;
  logic                 accept;
  logic                 chPending;
  logic                 overRange;
  logic [POS_W-1:0]     clampedPos;
  logic [N_CH-1:0]      load;
  logic [N_CH-1:0]      change;
  logic [N_CH-1:0]      hit;
  logic [CNT_W-1:0]     width [N_CH];

  // An out-of-range channel matches no pending bit, so it is accepted and then ignored.
  always_comb begin
    chPending = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(cmd_ch) == i) begin
        chPending = pending_q[i];
      end
    end
  end

  assign cmd_ready = alive_q & ~chPending;
  assign accept    = cmd_valid & cmd_ready;
  assign boundary  = (frameCnt_q == FRAME_LAST);
  assign overRange = (int'(cmd_pos) > MAX_POS);

  always_comb begin
    frameCnt_d = boundary ? '0 : frameCnt_q + CNT_W'(1);
    clampedPos = overRange ? POS_W'(MAX_POS) : cmd_pos;
    for (int i = 0; i < N_CH; i++) begin
      load[i]   = boundary & pending_q[i];
      change[i] = load[i] & (shadow_q[i] != active_q[i]);
      hit[i]    = accept & (int'(cmd_ch) == i);
      width[i]  = CNT_W'(MIN_PULSE_CYC) + CNT_W'(active_q[i]) * CNT_W'(STEP_CYC);
    end
  end

  // A channel accepting a command is never pending, so load and shadow write never collide.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      alive_q    <= 1'b0;
      frameCnt_q <= '0;
      pending_q  <= '0;
      pwm_q      <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= POS_W'(RESET_POS);
        active_q[i] <= POS_W'(RESET_POS);
        state_q[i]  <= IDLE;
        tmr_q[i]    <= '0;
      end
    end else begin
      alive_q    <= 1'b1;
      frameCnt_q <= frameCnt_d;
      err_q      <= accept & overRange;
      for (int i = 0; i < N_CH; i++) begin
        pwm_q[i]  <= (frameCnt_q < width[i]);
        done_q[i] <= 1'b0;
        if (load[i]) begin
          active_q[i]  <= shadow_q[i];
          pending_q[i] <= 1'b0;
        end
        if (hit[i]) begin
          shadow_q[i]  <= clampedPos;
          pending_q[i] <= 1'b1;
        end
        // A new position restarts the settle window even if the old one was about to expire.
        if (change[i]) begin
          state_q[i] <= MOVING;
          busy_q[i]  <= 1'b1;
          tmr_q[i]   <= '0;
        end else if (state_q[i] == MOVING) begin
          if (tmr_q[i] == SETTLE_LAST) begin
            state_q[i] <= IDLE;
            busy_q[i]  <= 1'b0;
            done_q[i]  <= 1'b1;
          end else begin
            tmr_q[i] <= tmr_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign pwm_out    = pwm_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign err_range  = err_q;

endmodule

// File: tb/tb_servo_bank_ctrl.sv
// Bench for servo_bank_ctrl: directed scenarios plus random commands and resets, all compared
// every cycle against a frame/deadline-based reference model.
module tb_servo_bank_ctrl;

  localparam int N_CH          = 2;
  localparam int POS_W         = 8;
  localparam int MAX_POS       = 80;
  localparam int RESET_POS     = 40;
  localparam int PERIOD_CYC    = 100;
  localparam int MIN_PULSE_CYC = 10;
  localparam int STEP_CYC      = 1;
  localparam int SETTLE_CYC    = 250;
  localparam int CNT_W         = 32;
  localparam int CH_W          = 1;

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch = '0;
  logic [POS_W-1:0]  cmd_pos = '0;
  logic [N_CH-1:0]   pwm_out;
  logic [N_CH-1:0]   busy;
  logic [N_CH-1:0]   done_pulse;
  logic              err_range;

  int checks = 0;
  int errors = 0;

  servo_bank_ctrl #(
    .N_CH(N_CH), .POS_W(POS_W), .MAX_POS(MAX_POS), .RESET_POS(RESET_POS),
    .PERIOD_CYC(PERIOD_CYC), .MIN_PULSE_CYC(MIN_PULSE_CYC), .STEP_CYC(STEP_CYC),
    .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr_n(clr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .pwm_out(pwm_out), .busy(busy),
    .done_pulse(done_pulse), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Reference model: frame position, positions per channel, and absolute settle deadlines.
  int          mFrame;
  int          mActive [N_CH];
  int          mShadow [N_CH];
  bit          mPend [N_CH];
  bit          mAlive;
  bit          mMoving [N_CH];
  longint      mMoveStart [N_CH];
  longint      mCyc = 0;
  bit [N_CH-1:0] mPwm, mBusy, mDone;
  bit          mErr;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int widthOf(input int pos);
    return MIN_PULSE_CYC + pos * STEP_CYC;
  endfunction

  task automatic modelReset();
    mFrame = 0;
    mAlive = 0;
    mPwm = '0;
    mBusy = '0;
    mDone = '0;
    mErr = 0;
    for (int i = 0; i < N_CH; i++) begin
      mActive[i] = RESET_POS;
      mShadow[i] = RESET_POS;
      mPend[i] = 0;
      mMoving[i] = 0;
      mMoveStart[i] = 0;
    end
  endtask

  function automatic bit modelReady();
    if (!mAlive) return 0;
    if (int'(cmd_ch) >= N_CH) return 1;
    return !mPend[int'(cmd_ch)];
  endfunction

  task automatic modelStep(input bit acc);
    bit atBoundary;
    mCyc++;
    atBoundary = (mFrame == PERIOD_CYC - 1);
    for (int i = 0; i < N_CH; i++) begin
      mPwm[i] = (mFrame < widthOf(mActive[i]));
      if (atBoundary && mPend[i]) begin
        if (mShadow[i] != mActive[i]) begin
          mMoving[i] = 1;
          mMoveStart[i] = mCyc;
        end
        mActive[i] = mShadow[i];
        mPend[i] = 0;
      end
    end
    mErr = acc && (int'(cmd_pos) > MAX_POS);
    if (acc && int'(cmd_ch) < N_CH) begin
      mShadow[int'(cmd_ch)] = (int'(cmd_pos) > MAX_POS) ? MAX_POS : int'(cmd_pos);
      mPend[int'(cmd_ch)] = 1;
    end
    mFrame = (mFrame + 1) % PERIOD_CYC;
    mAlive = 1;
    for (int i = 0; i < N_CH; i++) begin
      mBusy[i] = mMoving[i] && (mCyc < mMoveStart[i] + SETTLE_CYC);
      mDone[i] = mMoving[i] && (mCyc == mMoveStart[i] + SETTLE_CYC);
      if (mDone[i]) mMoving[i] = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("pwm_out", 32'(pwm_out), 32'(mPwm));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("done_pulse", 32'(done_pulse), 32'(mDone));
    checkOutput("err_range", 32'(err_range), 32'(mErr));
  endtask

  // One clock cycle: drive at the falling edge, check ready, step at rising edge, check outputs.
  task automatic applyStimulus(input bit v, input int ch, input int pos, output bit acc);
    bit expReady;
    cmd_valid = v;
    cmd_ch = CH_W'(ch);
    cmd_pos = POS_W'(pos);
    #1;
    expReady = modelReady();
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(expReady));
    acc = v && expReady;
    @(posedge clk);
    if (clr_n) modelStep(acc);
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) applyStimulus(0, 0, 0, acc);
  endtask

  task automatic sendCmd(input int ch, input int pos);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 400) begin
      applyStimulus(1, ch, pos, acc);
      n++;
    end
    checkOutput("cmd_accept_timeout", 32'(acc), 32'd1);
    cmd_valid = 0;
  endtask

  task automatic doReset(input int n);
    clr_n = 0;
    cmd_valid = 0;
    modelReset();
    #1;
    checkAll();
    checkOutput("cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    idle(n);
    clr_n = 1;
  endtask

  initial begin
    bit acc;
    modelReset();
    @(negedge clk);
    doReset(3);
    idle(150);

    idle(37);
    sendCmd(0, 20);
    idle(400);

    sendCmd(1, 60);
    applyStimulus(0, 0, 0, acc);
    sendCmd(1, 70);
    idle(300);

    sendCmd(1, 200);
    idle(300);

    sendCmd(0, 10);
    idle(150);
    doReset(3);
    idle(400);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        doReset(int'($urandom_range(1, 4)));
      end else begin
        applyStimulus($urandom_range(0, 15) == 0, int'($urandom_range(0, N_CH - 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(81, 255))
                                                  : int'($urandom_range(0, 80)), acc);
      end
    end
    cmd_valid = 0;
    idle(SETTLE_CYC + PERIOD_CYC + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
